// File: rtl/me_search_sched.sv
// Motion-estimation search-point scheduler: raster-walks the search grid, issues a
// reference-row burst per point, collects PE SAD results and keeps the best point.
//
// state    | meaning
// IDLE     | waiting for start; results held
// WAIT_REF | scan accepted, waiting for reference preload
// READ     | issuing ROWS reference row reads for point (x,y)
// WAIT_SAD | burst issued, waiting for the PE SAD of (x,y)
// DONE     | last point consumed, done pulse
module me_search_sched #(
  parameter int SR_W   = 8,
  parameter int SR_H   = 8,
  parameter int ROWS   = 4,
  parameter int ADDR_W = 7,
  parameter int MV_W   = 4,
  parameter int SAD_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              ref_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_address,
  output logic [MV_W-1:0]   rd_col,
  input  logic              pe_sad_valid,
  input  logic [SAD_W-1:0]  pe_sad,
  output logic              busy,
  output logic              done,
  output logic [SAD_W-1:0]  best_sad,
  output logic [MV_W-1:0]   best_mv_x,
  output logic [MV_W-1:0]   best_mv_y,
  output logic              err
);

  localparam int RC_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RC_W-1:0] ROW_LAST = RC_W'(ROWS - 1);
  localparam logic [MV_W-1:0] X_LAST   = MV_W'(SR_W - 1);
  localparam logic [MV_W-1:0] Y_LAST   = MV_W'(SR_H - 1);

  typedef enum logic [2:0] {IDLE, WAIT_REF, READ, WAIT_SAD, DONE} state_t;

  state_t          state, state_nxt;
  logic [MV_W-1:0] x, y;
  logic [RC_W-1:0] row_cnt;
  logic            last_pt;

  assign last_pt = (x == X_LAST) && (y == Y_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = WAIT_REF;
      WAIT_REF: if (ref_ready) state_nxt = READ;
      READ:     if (row_cnt == ROW_LAST) state_nxt = WAIT_SAD;
      WAIT_SAD: if (pe_sad_valid) state_nxt = last_pt ? DONE : READ;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // rd_* are registered from the current READ state, so each beat lags its row_cnt by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      row_cnt    <= '0;
      rd_en      <= 1'b0;
      rd_address <= '0;
      rd_col     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      best_sad   <= '1;
      best_mv_x  <= '0;
      best_mv_y  <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
      rd_en <= (state == READ) && !abort;
      if (state == READ) begin
        rd_address <= ADDR_W'(y) + ADDR_W'(row_cnt);
        rd_col     <= x;
      end
      if (abort) begin
        x         <= '0;
        y         <= '0;
        row_cnt   <= '0;
        best_sad  <= '1;
        best_mv_x <= '0;
        best_mv_y <= '0;
      end else begin
        if (pe_sad_valid && (state != WAIT_SAD)) err <= 1'b1;
        case (state)
          IDLE: begin
            if (start) begin
              x         <= '0;
              y         <= '0;
              best_sad  <= '1;
              best_mv_x <= '0;
              best_mv_y <= '0;
              err       <= 1'b0;
            end
          end
          WAIT_REF: row_cnt <= '0;
          READ:     row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + RC_W'(1);
          WAIT_SAD: begin
            if (pe_sad_valid) begin
              // strict compare keeps the earliest point on ties
              if (pe_sad < best_sad) begin
                best_sad  <= pe_sad;
                best_mv_x <= x;
                best_mv_y <= y;
              end
              if (!last_pt) begin
                if (x == X_LAST) begin
                  x <= '0;
                  y <= y + MV_W'(1);
                end else begin
                  x <= x + MV_W'(1);
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_me_search_sched.sv
// Randomized self-checking bench for me_search_sched: a scan-level model predicts
// the burst addresses, latencies and best-point result of every scan.
module tb_me_search_sched;

  localparam int SR_W = 8;
  localparam int SR_H = 8;
  localparam int ROWS = 4;
  localparam int NPTS = SR_W * SR_H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        ref_ready = 1'b0;
  logic        rd_en;
  logic [6:0]  rd_address;
  logic [3:0]  rd_col;
  logic        pe_sad_valid = 1'b0;
  logic [15:0] pe_sad = '0;
  logic        busy;
  logic        done;
  logic [15:0] best_sad;
  logic [3:0]  best_mv_x;
  logic [3:0]  best_mv_y;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int burst_cnt = 0;
  logic rd_en_q = 1'b0;
  logic [15:0] last_sad = 16'hFFFF;
  int last_x = 0;
  int last_y = 0;

  me_search_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ref_ready(ref_ready),
    .rd_en(rd_en), .rd_address(rd_address), .rd_col(rd_col),
    .pe_sad_valid(pe_sad_valid), .pe_sad(pe_sad), .busy(busy), .done(done),
    .best_sad(best_sad), .best_mv_x(best_mv_x), .best_mv_y(best_mv_y), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rd_en && !rd_en_q) burst_cnt++;
    rd_en_q = rd_en;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk_best(input string tag, input logic [15:0] s, input int bx, input int by);
    chk_val({tag, "_sad"}, 32'(best_sad), 32'(s));
    chk_val({tag, "_mv"}, {24'd0, best_mv_x, best_mv_y}, {24'd0, 4'(bx), 4'(by)});
  endtask

  // pat: 0 tie pattern, 1 random narrow range, 2 all-ones, 3 descending
  task automatic run_scan(input int pat, input int abort_pt, input bit restart_mid, input bit ref_delay);
    logic [15:0] sads [NPTS];
    logic [15:0] exp_sad;
    int ex, ey, cnt, d, done0, burst0;
    for (int p = 0; p < NPTS; p++) begin
      case (pat)
        0:       sads[p] = (p == 0) ? 16'd50 : (p == 1 || p == 2) ? 16'd30 : 16'd40;
        1:       sads[p] = 16'($urandom_range(20, 40));
        2:       sads[p] = 16'hFFFF;
        default: sads[p] = 16'(1000 - p);
      endcase
    end
    exp_sad = 16'hFFFF; ex = 0; ey = 0;
    for (int p = 0; p < NPTS; p++)
      if (sads[p] < exp_sad) begin
        exp_sad = sads[p]; ex = p % SR_W; ey = p / SR_W;
      end
    done0 = done_cnt;
    burst0 = burst_cnt;
    ref_ready = !ref_delay;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_val("err_clear_on_start", 32'(err), 32'd0);
    chk_val("busy_after_start", 32'(busy), 32'd1);
    if (ref_delay) begin
      for (int i = 0; i < 10; i++) begin
        chk_val("ref_wait_busy_rden", {30'd0, busy, rd_en}, 32'b10);
        tick();
      end
      ref_ready = 1'b1;
    end
    for (int p = 0; p < NPTS; p++) begin
      int px = p % SR_W;
      int py = p / SR_W;
      cnt = 0;
      while (!rd_en && cnt <= 20) begin
        tick();
        cnt++;
      end
      if (cnt > 20) begin
        chk_val("burst_timeout", 32'(cnt), 32'd0);
        return;
      end
      chk_val(p == 0 ? "first_rd_latency" : "point_rd_latency", 32'(cnt), p == 0 ? 32'd2 : 32'd1);
      if (p == 1) ref_ready = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        chk_val("burst_beat", {20'd0, rd_en, rd_address, rd_col}, {20'd0, 1'b1, 7'(py + r), 4'(px)});
        tick();
      end
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        chk_val("rd_idle_wait_sad", 32'(rd_en), 32'd0);
        tick();
      end
      if (restart_mid && p == 20) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      chk_val("rd_idle_before_sad", 32'(rd_en), 32'd0);
      if (p == abort_pt) begin
        abort = 1'b1;
        pe_sad_valid = 1'b1;
        pe_sad = 16'd0;
        tick();
        abort = 1'b0;
        pe_sad_valid = 1'b0;
        chk_val("abort_busy_rden", {30'd0, busy, rd_en}, 32'd0);
        chk_best("abort_best", 16'hFFFF, 0, 0);
        chk_val("abort_err_kept", 32'(err), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk_val("abort_no_done", 32'(done_cnt - done0), 32'd0);
        chk_val("abort_stays_idle", {30'd0, busy, rd_en}, 32'd0);
        last_sad = 16'hFFFF; last_x = 0; last_y = 0;
        return;
      end
      pe_sad_valid = 1'b1;
      pe_sad = sads[p];
      tick();
      pe_sad_valid = 1'b0;
    end
    chk_val("done_pulse_busy", {30'd0, done, busy}, 32'b11);
    tick();
    chk_val("after_done", {30'd0, done, busy}, 32'b00);
    chk_val("done_count", 32'(done_cnt - done0), 32'd1);
    chk_val("burst_count", 32'(burst_cnt - burst0), 32'(NPTS));
    chk_val("scan_err", 32'(err), 32'd0);
    chk_best("scan_best", exp_sad, ex, ey);
    last_sad = exp_sad; last_x = ex; last_y = ey;
    for (int i = 0; i < 3; i++) tick();
    chk_best("result_hold", exp_sad, ex, ey);
  endtask

  initial begin
    tick();
    chk_val("reset_ctrl", {26'd0, rd_en, busy, done, err, 2'b00}, 32'd0);
    chk_val("reset_rd", {21'd0, rd_address, rd_col}, 32'd0);
    chk_best("reset_best", 16'hFFFF, 0, 0);
    rst_n = 1'b1;
    tick();
    tick();

    run_scan(0, -1, 1'b0, 1'b0);

    pe_sad_valid = 1'b1;
    pe_sad = 16'd0;
    tick();
    pe_sad_valid = 1'b0;
    chk_val("idle_sad_sets_err", 32'(err), 32'd1);
    chk_best("idle_sad_best_kept", last_sad, last_x, last_y);
    tick();
    chk_val("err_sticky", 32'(err), 32'd1);

    run_scan(1, -1, 1'b0, 1'b1);
    run_scan(2, -1, 1'b1, 1'b0);
    run_scan(3, -1, 1'b0, 1'b0);
    run_scan(1, int'($urandom_range(1, NPTS - 2)), 1'b0, 1'b0);
    run_scan(1, -1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/me_search_sched.md
Name: me_search_sched

Overview:
- Search-point scheduler for the motion-estimation core.
- Once the reference bank memory reports its preload complete, it walks an SR_W x SR_H grid of integer search points in raster order.
- For each point it issues a ROWS-row read burst to the reference memory, waits for the PE array's SAD result, and tracks the minimum-SAD point.
- Sits between the global ME control and the reference memory controller / PE array.

Parameters:
SR_W, 8, search points per row (x range 0..SR_W-1)
SR_H, 8, search rows (y range 0..SR_H-1)
ROWS, 4, reference rows read per search point
ADDR_W, 7, reference memory row address width; SR_H+ROWS-1 must be <= 2^ADDR_W
MV_W, 4, width of x/y offset outputs; SR_W and SR_H must be <= 2^MV_W
SAD_W, 16, SAD width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a scan; sampled only in IDLE
abort  in  1  synchronous cancel; highest priority
ref_ready  in  1  level; reference memory preload complete
rd_en  out  1  reference read strobe, one row per cycle
rd_address  out  ADDR_W  reference row address
rd_col  out  MV_W  column (bank) offset for current point = x
pe_sad_valid  in  1  PE SAD result valid, 1-cycle pulse
pe_sad  in  SAD_W  SAD of current point
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse at scan end
best_sad  out  SAD_W  minimum SAD found
best_mv_x  out  MV_W  x of best point
best_mv_y  out  MV_W  y of best point
err  out  1  sticky protocol error

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk.
- Reset values:
  - rd_en=0, rd_address=0, rd_col=0, busy=0, done=0, err=0.
  - best_sad=all ones, best_mv_x=0, best_mv_y=0.
  - State IDLE; x, y and row_cnt all 0.
- All outputs are registered.
- States: IDLE, WAIT_REF, READ, WAIT_SAD, DONE.
- IDLE:
  - start=1 -> WAIT_REF.
  - On the same edge: x=y=0, best_sad=all ones, best_mv=0, err=0.
- WAIT_REF: ref_ready=1 -> READ with row_cnt=0. Otherwise stay, with rd_en=0.
- READ:
  - ROWS consecutive cycles with rd_en=1, rd_address=y+row_cnt (zero-extended to ADDR_W), rd_col=x.
  - After row_cnt=ROWS-1 -> WAIT_SAD.
  - rd_en drops to 0 on the next cycle.
- WAIT_SAD, on pe_sad_valid:
  - If pe_sad < best_sad (strict), load best_sad=pe_sad, best_mv_x=x, best_mv_y=y.
  - Ties keep the earlier point in raster order.
  - If x==SR_W-1 and y==SR_H-1 -> DONE.
  - Else if x==SR_W-1: x=0, y=y+1 -> READ.
  - Else x=x+1 -> READ.
- DONE: done=1 for exactly one cycle -> IDLE.
- Results hold until the next accepted start.
- ref_ready is checked only in WAIT_REF; a later drop does not stall the scan.
- start outside IDLE is ignored.
- pe_sad_valid outside WAIT_SAD:
  - Sets err=1.
  - Does not change the best_* outputs or the state.
  - err clears only on an accepted start or reset.
- A scan whose SADs all equal all-ones leaves best_sad=all ones and best_mv=(0,0).
- abort=1 in any state:
  - Next state IDLE; rd_en=0 on the next edge; no done pulse.
  - best_* return to reset values; err is retained.
  - abort overrides start and pe_sad_valid in the same cycle.
- Latency:
  - With ref_ready already high, the first rd_en is high 2 cycles after the edge that samples start.
  - Per point: ROWS read cycles + SAD wait + 1.

Test Plan:
- SR_W=SR_H=2, ref_ready=1, PE returns 50,30,30,40 -> best_sad=30, best_mv=(1,0) (tie on the third point not taken), one done pulse, busy low after done.
- Default params, point x=3,y=5 -> rd_address 5,6,7,8 on 4 consecutive cycles, rd_col=3, then rd_en=0 until the next pe_sad_valid.
- start with ref_ready=0 for 10 cycles -> busy=1, rd_en=0 throughout; rd_en rises 2 cycles after ref_ready goes high.
- abort asserted in WAIT_SAD together with pe_sad_valid -> IDLE next cycle, rd_en=0, done never pulses, best_sad=0xFFFF, best_mv=(0,0).
- pe_sad_valid pulse in IDLE -> err=1, best outputs unchanged; a following start clears err to 0.
- start pulsed again mid-scan, and all SADs 0xFFFF -> second start ignored, exactly SR_W*SR_H bursts issued, best_sad=0xFFFF, best_mv=(0,0).
